// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: sits around the multdiv unit. Latches a decoded
// mult/div instruction, issues a one-cycle start pulse with operands held
// stable, stalls the pipeline while the unit iterates, and hands the result
// back to writeback as a one-cycle strobe. A WAIT timeout forces completion
// with an exception.
// Optional build macro MULTDIV_RSTATUS_EN: on any exception, redirect the
// writeback to rstatus (r30) with code 4 (mult) or 5 (div).
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_exc_q, wb_exc_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall is the only combinational output: it must freeze the pipeline in
  // the same cycle the instruction is first presented.
  assign stall = (state_q == S_IDLE && issue_valid) ||
                 (state_q == S_START) || (state_q == S_WAIT);

  // Next-state and registered-output logic for the issue/wait/writeback FSM.
  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    rd_d       = rd_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          is_div_d = issue_is_div;
          rd_d     = issue_rd;
          opa_d    = issue_opA;
          opb_d    = issue_opB;
          // Pulse is registered so it lines up with the START state.
          mult_d   = ~issue_is_div;
          div_d    = issue_is_div;
          state_d  = S_START;
        end
      end
      S_START: begin
        // RDY here belongs to a previous operation and is ignored.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // RDY takes priority over a coincident timeout.
        if (md_resultRDY || timeout) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = md_resultRDY ? md_result : '0;
          wb_exc_d   = md_resultRDY ? md_exception : 1'b1;
`ifdef MULTDIV_RSTATUS_EN
          if (wb_exc_d) begin
            wb_rd_d   = 5'd30;
            wb_data_d = {29'd0, (is_div_q ? 3'd5 : 3'd4)};
          end
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any
  // in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      rd_q       <= rd_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl. Stimulus tasks push the expected
// writeback into a scoreboard queue; a monitor pops and compares on every
// wb_valid. Cycle-accurate checks (pulses, stall, operand hold) are inline.
module tb_multdiv_issue_ctrl;

  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_opA;
  logic [31:0] issue_opB;
  logic [4:0]  issue_rd;
  logic        stall;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .stall(stall),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  logic prev_wbv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected writeback for a completed operation.
  function automatic exp_t expect_wb(input bit is_div, input logic [4:0] rd,
                                     input logic [31:0] res, input bit exc);
    exp_t e;
    e.rd   = rd;
    e.data = res;
    e.exc  = exc;
`ifdef MULTDIV_RSTATUS_EN
    if (exc) begin
      e.rd   = 5'd30;
      e.data = is_div ? 32'd5 : 32'd4;
    end
`endif
    return e;
  endfunction

  // Monitor: every wb_valid must match the oldest expectation and be one cycle wide.
  always @(negedge clock) begin
    if (reset) begin
      prev_wbv = 1'b0;
    end else begin
      if (wb_valid) begin
        exp_t e;
        chk("wb_valid_width", {31'd0, prev_wbv}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wb_valid: actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_data", wb_data, e.data);
          chk("wb_exception", {31'd0, wb_exception}, {31'd0, e.exc});
        end
      end
      prev_wbv = wb_valid;
    end
  end

  // Issue one instruction from IDLE and model the unit asserting RDY k cycles
  // after the pulse (k <= 0: never). Returns during the DONE cycle.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input logic [31:0] res,
                        input bit exc, input bit stale);
    int  done_c;
    bit  seen;
    done_c = (k > 0) ? k + 2 : TO + 2;
    seen   = 1'b0;
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_opA    = a;
    issue_opB    = b;
    issue_rd     = rd;
    if (k > 0) sb.push_back(expect_wb(is_div, rd, res, exc));
    else       sb.push_back(expect_wb(is_div, rd, 32'd0, 1'b1));
    #1;
    chk("stall_issue", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clock);
      #1;
      md_resultRDY = (k > 0 && c == k + 1);
      if (md_resultRDY) begin
        md_result    = res;
        md_exception = exc;
      end
      if (c == 1) begin
        chk("ctrl_MULT_pulse", {31'd0, md_ctrl_MULT}, {31'd0, !is_div});
        chk("ctrl_DIV_pulse", {31'd0, md_ctrl_DIV}, {31'd0, is_div});
        if (stale) begin
          md_resultRDY = 1'b1;
          md_result    = 32'hDEAD_BEEF;
          md_exception = 1'b1;
        end
      end else begin
        chk("ctrl_MULT_idle", {31'd0, md_ctrl_MULT}, 32'd0);
        chk("ctrl_DIV_idle", {31'd0, md_ctrl_DIV}, 32'd0);
      end
      if (stale && c == 3) issue_opA = ~a;
      if (c < done_c) begin
        chk("md_operandA_hold", md_operandA, a);
        chk("md_operandB_hold", md_operandB, b);
      end
      if (wb_valid) begin
        seen = 1'b1;
        chk("wb_valid_cycle", c, done_c);
        chk("stall_done", {31'd0, stall}, 32'd0);
        issue_valid = 1'b0;
      end else begin
        chk("stall_busy", {31'd0, stall}, 32'd1);
      end
    end
    md_resultRDY = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wb_valid_timeout: actual=none required=cycle %0d", done_c);
      issue_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=hung required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_opA    = '0;
    issue_opB    = '0;
    issue_rd     = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    chk("rst_operandA", md_operandA, 32'd0);
    chk("rst_operandB", md_operandB, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd_exc", {26'd0, wb_rd, wb_exception}, 32'd0);
    reset = 1'b0;
    tick();

    // Multiply 7*6, RDY 17 cycles after pulse.
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 17, 32'd42, 1'b0, 1'b0);
    tick();
    // Divide by zero with exception.
    run_op(1'b1, 32'd100, 32'd0, 5'd9, 6, 32'd0, 1'b1, 1'b0);
    tick();
    // Timeout: RDY never arrives.
    run_op(1'b0, 32'd11, 32'd13, 5'd12, 0, 32'd0, 1'b0, 1'b0);
    tick();
    // RDY coincides with timeout cycle: RDY wins.
    run_op(1'b0, 32'd1, 32'd1, 5'd7, TO, 32'd1, 1'b0, 1'b0);
    tick();
    // Stale RDY during START and opA changed during WAIT.
    run_op(1'b0, 32'd5, 32'd5, 5'd4, 3, 32'd25, 1'b0, 1'b1);
    tick();
    // rd = 0 still reported; RDY in first WAIT cycle.
    run_op(1'b0, 32'd2, 32'd3, 5'd0, 1, 32'd6, 1'b0, 1'b0);
    tick();

    // Reset 5 cycles after the pulse aborts the operation.
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_opA    = 32'd8;
    issue_opB    = 32'd8;
    issue_rd     = 5'd2;
    tick();
    chk("abort_pulse", {31'd0, md_ctrl_MULT}, 32'd1);
    repeat (5) tick();
    reset       = 1'b1;
    issue_valid = 1'b0;
    tick();
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
      chk("abort_idle_stall", {31'd0, stall}, 32'd0);
    end
    run_op(1'b0, 32'd3, 32'd3, 5'd1, 4, 32'd9, 1'b0, 1'b0);
    tick();

    // Back-to-back: next instruction presented during DONE must wait for IDLE.
    run_op(1'b0, 32'd7, 32'd6, 5'd5, 2, 32'd42, 1'b0, 1'b0);
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_opA    = 32'd84;
    issue_opB    = 32'd4;
    issue_rd     = 5'd6;
    #1;
    chk("b2b_done_stall", {31'd0, stall}, 32'd0);
    tick();
    run_op(1'b1, 32'd84, 32'd4, 5'd6, 5, 32'd21, 1'b0, 1'b0);
    repeat (4) tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
